quad_encoder_bank: RTL

QUAD_ENCODER_BANK -- requirements
Module: quad_encoder_bank

---
 rtl/quad_encoder_bank.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/quad_encoder_bank.sv
// Quadrature encoder bank: per-channel sync + glitch filter + x4 decoder,
// coherent snapshot shadows, windowed velocity and a registered read port.
module quad_encoder_bank #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned FILT_LEN   = 3,
    parameter int unsigned VEL_PERIOD = 50000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] enc_a,
    input  logic [N_CH-1:0] enc_b,
    input  logic            snap_req,
    input  logic            clr_stb,
    input  logic [N_CH-1:0] clr_mask,
    input  logic [7:0]      rd_addr,
    output logic [31:0]     rd_data,
    output logic            err_any
);

    localparam int unsigned WIN_W = (VEL_PERIOD > 1) ? $clog2(VEL_PERIOD) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(VEL_PERIOD - 1);

    logic [N_CH-1:0]                a_s1, b_s1;
    logic [N_CH-1:0][FILT_LEN-1:0]  a_sh, b_sh;
    logic [N_CH-1:0]                a_flt, b_flt, a_prev, b_prev;
    logic [N_CH-1:0][CNT_W-1:0]     live, live_nxt, shadow, ref_cnt, vel;
    logic [N_CH-1:0]                err, err_nxt;
    logic [N_CH-1:0][1:0]           diff;
    logic [7:0]                     seq;
    logic [WIN_W-1:0]               win;
    logic                           win_tc;
    logic [31:0]                    rd_nxt;

    // Gray position of an (A,B) pair: 00->0, 10->1, 11->2, 01->3
    function automatic logic [1:0] gray_pos(input logic a, input logic b);
        return {b, a ^ b};
    endfunction

    assign win_tc = (win == WIN_LAST);

    // Two-flop sync; sh[0] is the second sync stage and the window holds the last FILT_LEN samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_s1   <= '0;
            b_s1   <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            a_flt  <= '0;
            b_flt  <= '0;
            a_prev <= '0;
            b_prev <= '0;
        end else begin
            a_s1   <= enc_a;
            b_s1   <= enc_b;
            a_prev <= a_flt;
            b_prev <= b_flt;
            for (int unsigned i = 0; i < N_CH; i++) begin
                a_sh[i] <= FILT_LEN'({a_sh[i], a_s1[i]});
                b_sh[i] <= FILT_LEN'({b_sh[i], b_s1[i]});
                if (&a_sh[i] || ~|a_sh[i]) a_flt[i] <= a_sh[i][0];
                if (&b_sh[i] || ~|b_sh[i]) b_flt[i] <= b_sh[i][0];
            end
        end
    end

    // Decode filtered transitions into step/jump, then apply clear with priority
    always_comb begin
        diff     = '0;
        live_nxt = live;
        err_nxt  = err;
        for (int unsigned i = 0; i < N_CH; i++) begin
            diff[i] = gray_pos(a_flt[i], b_flt[i]) - gray_pos(a_prev[i], b_prev[i]);
            case (diff[i])
                2'd1:    live_nxt[i] = live[i] + CNT_W'(1);
                2'd3:    live_nxt[i] = live[i] - CNT_W'(1);
                2'd2:    err_nxt[i]  = 1'b1;
                default: ;
            endcase
            if (clr_stb && clr_mask[i]) begin
                live_nxt[i] = '0;
                err_nxt[i]  = 1'b0;
            end
        end
    end

    // Live counts and sticky errors
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live    <= '0;
            err     <= '0;
            err_any <= 1'b0;
        end else begin
            live    <= live_nxt;
            err     <= err_nxt;
            err_any <= |err_nxt;
        end
    end

    // Snapshot takes the pre-update live set so a coincident clear still reports old counts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
            seq    <= '0;
        end else if (snap_req) begin
            shadow <= live;
            seq    <= seq + 8'd1;
        end
    end

    // Velocity window: difference of live against the reference taken one window earlier
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win     <= '0;
            vel     <= '0;
            ref_cnt <= '0;
        end else begin
            win <= win_tc ? '0 : win + WIN_W'(1);
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (win_tc) begin
                    vel[i]     <= live[i] - ref_cnt[i];
                    ref_cnt[i] <= live[i];
                end
                if (clr_stb && clr_mask[i]) ref_cnt[i] <= '0;
            end
        end
    end

    // Register map decode
    always_comb begin
        rd_nxt = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (rd_addr == 8'(i))         rd_nxt = 32'(shadow[i]);
            if (rd_addr == 8'(32'h10 + i)) rd_nxt = 32'($signed(vel[i]));
        end
        if (rd_addr == 8'h20) rd_nxt = 32'(err);
        if (rd_addr == 8'h21) rd_nxt = 32'(seq);
    end

    // Registered read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_data <= '0;
        else          rd_data <= rd_nxt;
    end

endmodule
